// File: rtl/binary_pack_unit.sv
// Binary pack unit: reads four interleaved PE result lanes, thresholds each pixel
// to its MSB, packs 32 pixels per word into the pack buffer and counts foreground.
module binary_pack_unit #(
  parameter int N_PER_PE = 256,
  parameter int IDX_W    = 8,
  parameter int WADDR_W  = 5,
  parameter int CNT_W    = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pack_start,
  output logic               pack_done,
  output logic               pe_rd_en,
  output logic [IDX_W-1:0]   pe_rd_addr,
  input  logic [31:0]        pe_rd_data,
  output logic               wr_en,
  output logic [WADDR_W-1:0] wr_addr,
  output logic [31:0]        wr_data,
  output logic [CNT_W-1:0]   fg_count
);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_PER_PE - 1);
  localparam logic [WADDR_W-1:0] LAST_WADDR = WADDR_W'(N_PER_PE / 8 - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t           state;
  logic             vld_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [31:0]      acc_p1;
  logic [31:0]      acc_next;
  logic [3:0]       nib;

  function automatic logic [3:0] lane_bits(input logic [31:0] d);
    lane_bits = {d[31], d[23], d[15], d[7]};
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] b);
    popcnt4 = {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
  endfunction

  // Insert the thresholded nibble for index idx_p0 into the word being built.
  always_comb begin
    nib      = lane_bits(pe_rd_data);
    acc_next = acc_p1;
    acc_next[{idx_p0[2:0], 2'b00} +: 4] = nib;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pack_done  <= 1'b0;
      pe_rd_en   <= 1'b0;
      pe_rd_addr <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      fg_count   <= '0;
      vld_p0     <= 1'b0;
      idx_p0     <= '0;
      acc_p1     <= '0;
    end else begin
      // Stage p0: RAM read issued last cycle, data appears on pe_rd_data now.
      vld_p0 <= pe_rd_en;
      idx_p0 <= pe_rd_addr;
      wr_en  <= 1'b0;

      // Stage p1: accumulate the nibble and emit the word on its eighth index.
      if (vld_p0) begin
        acc_p1   <= acc_next;
        fg_count <= fg_count + CNT_W'(popcnt4(nib));
        if (idx_p0[2:0] == 3'b111) begin
          wr_en   <= 1'b1;
          wr_addr <= WADDR_W'(idx_p0 >> 3);
          wr_data <= acc_next;
        end
      end

      case (state)
        IDLE: begin
          if (pack_start) begin
            state      <= READ;
            pe_rd_en   <= 1'b1;
            pe_rd_addr <= '0;
            fg_count   <= '0;
            acc_p1     <= '0;
          end
        end
        READ: begin
          if (pe_rd_addr == LAST_IDX) begin
            pe_rd_en <= 1'b0;
            state    <= DRAIN;
          end else begin
            pe_rd_addr <= pe_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (wr_en && wr_addr == LAST_WADDR) begin
            state     <= DONE;
            pack_done <= 1'b1;
          end
        end
        DONE: begin
          if (!pack_start) begin
            pack_done <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
